// File: rtl/round_ctrl_if.sv
// Bundle of the game-flow signals exchanged between the round sequencer and
// the rest of the game: start request, player tiles, explosion grid in; state,
// gating and timing information out.
interface round_ctrl_if;
    // Requests and game-field observations
    logic         start;
    logic [7:0]   p1_cor;
    logic [7:0]   p2_cor;
    logic [255:0] explode;

    // Sequencer status and controls
    logic [2:0]   state;
    logic         play_en;
    logic         field_clr;
    logic [1:0]   winner;
    logic [3:0]   countdown;
    logic [7:0]   round_time;
    logic         sec_tick;

    // Side that drives requests and observes the sequencer
    modport master (
        output start,
        output p1_cor,
        output p2_cor,
        output explode,
        input  state,
        input  play_en,
        input  field_clr,
        input  winner,
        input  countdown,
        input  round_time,
        input  sec_tick
    );

    // The round sequencer itself
    modport slave (
        input  start,
        input  p1_cor,
        input  p2_cor,
        input  explode,
        output state,
        output play_en,
        output field_clr,
        output winner,
        output countdown,
        output round_time,
        output sec_tick
    );
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: top-level flow of the two-player bomb game.
// IDLE -> CLEAR (one cycle, re-initialises the field) -> COUNTDOWN -> PLAY ->
// OVER. Player input is gated by play_en, and the winner is decided from the
// explosion grid at each player's tile or by the round timer running out.
module round_ctrl #(
    parameter int TICKS_PER_SEC = 30,
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 180
) (
    input  logic        clk,
    input  logic        rst,
    round_ctrl_if.slave bus
);

    localparam int                TICK_W    = $clog2(TICKS_PER_SEC);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [3:0]        CD_LOAD   = 4'(COUNTDOWN_SEC);
    localparam logic [7:0]        RT_LOAD   = 8'(ROUND_SEC);

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_PLAY      = 3'd3,
        ST_OVER      = 3'd4
    } state_e;

    // A player is hit when the explosion flag of the tile they stand on is set.
    // The coordinate is used directly as the flat tile index.
    function automatic logic tile_hit(input logic [255:0] grid, input logic [7:0] cor);
        return grid[cor];
    endfunction

    state_e            state_r;
    logic [TICK_W-1:0] tick_r;
    logic              start_q_r;
    logic [3:0]        countdown_r;
    logic [7:0]        round_time_r;
    logic [1:0]        winner_r;
    logic              sec_tick_r;

    logic              start_evt_s;
    logic              h1_s;
    logic              h2_s;
    logic              tick_term_s;

    // Derive the start edge, both player hits and the end-of-second condition.
    always_comb begin
        start_evt_s = 1'b0;
        h1_s        = 1'b0;
        h2_s        = 1'b0;
        tick_term_s = 1'b0;
        if (bus.start && !start_q_r) begin
            start_evt_s = 1'b1;
        end else begin
            start_evt_s = 1'b0;
        end
        h1_s = tile_hit(bus.explode, bus.p1_cor);
        h2_s = tile_hit(bus.explode, bus.p2_cor);
        if (tick_r == TICK_LAST) begin
            tick_term_s = 1'b1;
        end else begin
            tick_term_s = 1'b0;
        end
    end

    // Round sequencer: state, second counter, timers, winner and tick pulse.
    // start_q resets high so a start level held across reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            tick_r       <= TICK_ZERO;
            start_q_r    <= 1'b1;
            countdown_r  <= 4'd0;
            round_time_r <= 8'd0;
            winner_r     <= WIN_NONE;
            sec_tick_r   <= 1'b0;
        end else begin
            start_q_r  <= bus.start;
            sec_tick_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tick_r      <= TICK_ZERO;
                    countdown_r <= 4'd0;
                    if (start_evt_s) begin
                        winner_r <= WIN_NONE;
                        state_r  <= ST_CLEAR;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end

                ST_CLEAR: begin
                    winner_r    <= WIN_NONE;
                    tick_r      <= TICK_ZERO;
                    countdown_r <= CD_LOAD;
                    state_r     <= ST_COUNTDOWN;
                end

                ST_COUNTDOWN: begin
                    if (tick_term_s) begin
                        tick_r     <= TICK_ZERO;
                        sec_tick_r <= 1'b1;
                        // A zero count can only come from a corrupted register;
                        // leaving for PLAY then avoids stalling forever.
                        if (countdown_r <= 4'd1) begin
                            countdown_r  <= 4'd0;
                            round_time_r <= RT_LOAD;
                            state_r      <= ST_PLAY;
                        end else begin
                            countdown_r  <= countdown_r - 4'd1;
                        end
                    end else begin
                        tick_r <= tick_r + TICK_ONE;
                    end
                end

                ST_PLAY: begin
                    if (tick_term_s) begin
                        sec_tick_r <= 1'b1;
                    end else begin
                        sec_tick_r <= 1'b0;
                    end
                    // A hit beats a timeout in the same cycle and freezes the
                    // displayed time at its current value.
                    if (h1_s || h2_s) begin
                        tick_r  <= TICK_ZERO;
                        state_r <= ST_OVER;
                        if (h1_s && h2_s) begin
                            winner_r <= WIN_DRAW;
                        end else if (h1_s) begin
                            winner_r <= WIN_P2;
                        end else begin
                            winner_r <= WIN_P1;
                        end
                    end else if (tick_term_s) begin
                        tick_r <= TICK_ZERO;
                        if (round_time_r <= 8'd1) begin
                            round_time_r <= 8'd0;
                            winner_r     <= WIN_DRAW;
                            state_r      <= ST_OVER;
                        end else begin
                            round_time_r <= round_time_r - 8'd1;
                        end
                    end else begin
                        tick_r <= tick_r + TICK_ONE;
                    end
                end

                ST_OVER: begin
                    tick_r <= TICK_ZERO;
                    if (start_evt_s) begin
                        winner_r <= WIN_NONE;
                        state_r  <= ST_CLEAR;
                    end else begin
                        state_r  <= ST_OVER;
                    end
                end

                default: begin
                    tick_r      <= TICK_ZERO;
                    countdown_r <= 4'd0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers or from a decode of the state register.
    assign bus.state      = state_r;
    assign bus.play_en    = (state_r == ST_PLAY);
    assign bus.field_clr  = (state_r == ST_CLEAR);
    assign bus.winner     = winner_r;
    assign bus.countdown  = countdown_r;
    assign bus.round_time = round_time_r;
    assign bus.sec_tick   = sec_tick_r;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: two instances (default round length and a 2-second
// round) share one stimulus. A timing-formula model predicts every output of
// both each cycle; directed literal checks pin the model to known values.
module tb_round_ctrl;

    localparam int T   = 30;
    localparam int C   = 3;
    localparam int R_A = 180;
    localparam int R_B = 2;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         start   = 1'b0;
    logic [7:0]   p1_cor  = 8'h00;
    logic [7:0]   p2_cor  = 8'h00;
    logic [255:0] explode = {256{1'b0}};

    int cyc      = -1;
    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: phase, entry cycle, winner, held time, start_q, tick-on-entry
    int m_ph  [2];
    int m_t0  [2];
    int m_win [2];
    int m_rt  [2];
    int m_sq  [2];
    int m_ovt [2];

    round_ctrl_if ifa ();
    round_ctrl_if ifb ();

    assign ifa.start   = start;
    assign ifa.p1_cor  = p1_cor;
    assign ifa.p2_cor  = p2_cor;
    assign ifa.explode = explode;
    assign ifb.start   = start;
    assign ifb.p1_cor  = p1_cor;
    assign ifb.p2_cor  = p2_cor;
    assign ifb.explode = explode;

    round_ctrl #(.TICKS_PER_SEC(T), .COUNTDOWN_SEC(C), .ROUND_SEC(R_A)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    round_ctrl #(.TICKS_PER_SEC(T), .COUNTDOWN_SEC(C), .ROUND_SEC(R_B)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i]  = 0;
            m_t0[i]  = 0;
            m_win[i] = 0;
            m_rt[i]  = 0;
            m_sq[i]  = 1;
            m_ovt[i] = 0;
        end
    endtask

    // Advance instance i by one clock using the inputs of the cycle just ending.
    task automatic model_step(input int i);
        int  r;
        int  e;
        int  ev;
        int  h1;
        int  h2;
        r  = (i == 0) ? R_A : R_B;
        e  = cyc - m_t0[i];
        ev = (start == 1'b1 && m_sq[i] == 0) ? 1 : 0;
        m_sq[i] = (start == 1'b1) ? 1 : 0;
        case (m_ph[i])
            0, 4: if (ev == 1) begin
                m_ph[i] = 1; m_win[i] = 0; m_t0[i] = cyc + 1;
            end
            1: begin
                m_ph[i] = 2; m_t0[i] = cyc + 1;
            end
            2: if (e == C * T - 1) begin
                m_ph[i] = 3; m_t0[i] = cyc + 1;
            end
            3: begin
                h1 = (explode[p1_cor] == 1'b1) ? 1 : 0;
                h2 = (explode[p2_cor] == 1'b1) ? 1 : 0;
                if (h1 == 1 || h2 == 1) begin
                    m_rt[i]  = r - e / T;
                    m_win[i] = (h1 == 1 && h2 == 1) ? 3 : ((h1 == 1) ? 2 : 1);
                    m_ovt[i] = (e % T == T - 1) ? 1 : 0;
                    m_ph[i]  = 4; m_t0[i] = cyc + 1;
                end else if (e == r * T - 1) begin
                    m_rt[i] = 0; m_win[i] = 3; m_ovt[i] = 1;
                    m_ph[i] = 4; m_t0[i] = cyc + 1;
                end
            end
            default: ;
        endcase
    endtask

    // Compare every output of instance i against what the model predicts now.
    task automatic model_cmp(input int i, input int st, input int pe, input int fc,
                             input int w, input int cd, input int rt, input int stk);
        int r;
        int e;
        int x_cd;
        int x_rt;
        int x_stk;
        r     = (i == 0) ? R_A : R_B;
        e     = cyc - m_t0[i];
        x_cd  = (m_ph[i] == 2) ? C - e / T : 0;
        x_rt  = (m_ph[i] == 3) ? r - e / T : m_rt[i];
        x_stk = 0;
        if (m_ph[i] == 2) x_stk = (e > 0 && e % T == 0) ? 1 : 0;
        if (m_ph[i] == 3) x_stk = (e % T == 0) ? 1 : 0;
        if (m_ph[i] == 4) x_stk = (e == 0 && m_ovt[i] == 1) ? 1 : 0;
        chk("state", i, st, m_ph[i]);
        chk("play_en", i, pe, (m_ph[i] == 3) ? 1 : 0);
        chk("field_clr", i, fc, (m_ph[i] == 1) ? 1 : 0);
        chk("winner", i, w, m_win[i]);
        chk("countdown", i, cd, x_cd);
        chk("round_time", i, rt, x_rt);
        chk("sec_tick", i, stk, x_stk);
    endtask

    // Model/compare process: step on the rising edge, check 1 time unit later.
    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
                cyc = -1;
            end else begin
                model_step(0);
                model_step(1);
                cyc++;
            end
            #1;
            model_cmp(0, ifa.state, ifa.play_en, ifa.field_clr, ifa.winner,
                      ifa.countdown, ifa.round_time, ifa.sec_tick);
            model_cmp(1, ifb.state, ifb.play_en, ifb.field_clr, ifb.winner,
                      ifb.countdown, ifb.round_time, ifb.sec_tick);
        end
    end

    // Wait (bounded) until the falling edge inside cycle n.
    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) chk("wait_timeout", 0, cyc, n);
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_state", 0, ifa.state, 0);
        chk("rst_winner", 0, ifa.winner, 0);
        chk("rst_round_time", 0, ifa.round_time, 0);
        chk("rst_countdown", 0, ifa.countdown, 0);
        chk("rst_field_clr", 0, ifa.field_clr, 0);
        rst = 1'b0;

        // Start edge at cycle 10, countdown, then PLAY at 102
        wait_cyc(10);  start = 1'b1;
        wait_cyc(11);  chk("lit_fclr_11", 0, ifa.field_clr, 1);
        wait_cyc(12);  chk("lit_cd_12", 0, ifa.countdown, 3);
                       chk("lit_fclr_12", 0, ifa.field_clr, 0);
        wait_cyc(20);  start = 1'b0;
        wait_cyc(42);  chk("lit_cd_42", 0, ifa.countdown, 2);
                       chk("lit_tick_42", 0, ifa.sec_tick, 1);
        wait_cyc(72);  chk("lit_cd_72", 0, ifa.countdown, 1);
        wait_cyc(101); chk("lit_state_101", 0, ifa.state, 2);
        wait_cyc(102); chk("lit_state_102", 0, ifa.state, 3);
                       chk("lit_rt_102", 0, ifa.round_time, 180);
                       chk("lit_rt_102", 1, ifb.round_time, 2);

        // Short round times out 60 cycles after PLAY entry
        wait_cyc(161); chk("lit_state_161", 1, ifb.state, 3);
        wait_cyc(162); chk("lit_state_162", 1, ifb.state, 4);
                       chk("lit_win_162", 1, ifb.winner, 3);
                       chk("lit_rt_162", 1, ifb.round_time, 0);

        // Start edge: restarts the finished round, ignored by the one in PLAY
        wait_cyc(164); start = 1'b1;
        wait_cyc(165); chk("lit_state_165", 0, ifa.state, 3);
                       chk("lit_state_165", 1, ifb.state, 1);
        wait_cyc(166); start = 1'b0;
                       chk("lit_win_166", 1, ifb.winner, 0);

        // Player 1 on exploding tile 0x21 for one cycle
        wait_cyc(170); p1_cor = 8'h21; p2_cor = 8'h00; explode[33] = 1'b1;
        wait_cyc(171); explode = {256{1'b0}};
                       chk("lit_state_171", 0, ifa.state, 4);
                       chk("lit_win_171", 0, ifa.winner, 2);
                       chk("lit_pe_171", 0, ifa.play_en, 0);
                       chk("lit_rt_171", 0, ifa.round_time, 178);

        // Both players hit on the last tick of the final second
        wait_cyc(256); chk("lit_state_256", 1, ifb.state, 3);
        wait_cyc(315); chk("lit_rt_315", 1, ifb.round_time, 1);
                       p1_cor = 8'h21; p2_cor = 8'h5A;
                       explode[33] = 1'b1; explode[90] = 1'b1;
        wait_cyc(316); explode = {256{1'b0}};
                       chk("lit_state_316", 1, ifb.state, 4);
                       chk("lit_win_316", 1, ifb.winner, 3);
                       chk("lit_rt_316", 1, ifb.round_time, 1);

        // Start held high across reset release does not trigger
        wait_cyc(320); start = 1'b1;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cyc(20);  chk("lit_held_idle", 0, ifa.state, 0);
                       chk("lit_held_idle", 1, ifb.state, 0);
                       start = 1'b0;
        wait_cyc(25);  start = 1'b1;
        wait_cyc(30);  start = 1'b0;

        // Asynchronous reset in the middle of the countdown
        wait_cyc(60);  chk("lit_cd_60", 0, ifa.countdown, 2);
        #2 rst = 1'b1;
        #1 chk("lit_arst_state", 0, ifa.state, 0);
           chk("lit_arst_cd", 0, ifa.countdown, 0);
           chk("lit_arst_fclr", 0, ifa.field_clr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cyc(10);  chk("lit_no_fclr", 0, ifa.field_clr, 0);
                       start = 1'b1;
        wait_cyc(11);  chk("lit_fclr_again", 0, ifa.field_clr, 1);
        wait_cyc(20);  start = 1'b0;

        // Player 2 hit only
        wait_cyc(110); p1_cor = 8'h00; p2_cor = 8'hF0; explode[240] = 1'b1;
        wait_cyc(111); explode = {256{1'b0}};
                       chk("lit_win_p1", 0, ifa.winner, 1);
                       chk("lit_win_p1", 1, ifb.winner, 1);
        wait_cyc(115);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Round sequencer for the two-player bomb game. It owns the top-level game flow: idle, arena clear, pre-round countdown, play, and game over. It gates player input via `play_en` and pulses `field_clr` to re-initialise the wall, gadget and bomb blocks. It also decides the winner from the explosion grid and the player tile coordinates. It runs in the game-tick clock domain, alongside the controller, bomb, Wall and Gadget blocks.

## Interface
- `TICKS_PER_SEC`, 30, game-clock cycles per displayed second (≥2)
- `COUNTDOWN_SEC`, 3, pre-round countdown length in seconds (1..15)
- `ROUND_SEC`, 180, round time limit in seconds (1..255)

- `clk`  in  1  game clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  start/restart request, level; the block edge-detects it internally
- `p1_cor`  in  8  player 1 tile index {y[3:0], x[3:0]}
- `p2_cor`  in  8  player 2 tile index
- `explode`  in  256  per-tile explosion flags from the bomb block
- `state`  out  3  IDLE=0, CLEAR=1, COUNTDOWN=2, PLAY=3, OVER=4
- `play_en`  out  1  high only in PLAY; enables the movement and bomb-placement controller
- `field_clr`  out  1  one-cycle pulse; re-initialises Wall, Gadget and bomb
- `winner`  out  2  0 = none, 1 = P1 wins, 2 = P2 wins, 3 = draw
- `countdown`  out  4  seconds remaining in COUNTDOWN; 0 otherwise
- `round_time`  out  8  seconds remaining in PLAY; holds its value in OVER
- `sec_tick`  out  1  one-cycle pulse at each second boundary in COUNTDOWN and PLAY

## Operation
- Reset values: `state`=IDLE, `play_en`=0, `field_clr`=0, `winner`=0, `countdown`=0, `round_time`=0, `sec_tick`=0.
- Internal state on reset: tick counter = 0, `start_q` = 1. Because `start_q` resets to 1, a `start` held across reset does not trigger.
- Start event: `start & ~start_q`, with `start_q` registered every cycle. Start events are honoured only in IDLE and OVER and are ignored elsewhere.
- **IDLE**: on a start event, go to CLEAR.
- **CLEAR**: lasts exactly one cycle.
  - `field_clr`=1 and `winner` is cleared to 0.
  - Next state is COUNTDOWN, with `countdown`=COUNTDOWN_SEC and tick counter = 0.
- **COUNTDOWN**: the tick counter counts 0..TICKS_PER_SEC-1 and then wraps.
  - On terminal count, `sec_tick`=1.
  - If `countdown`==1: go to PLAY, with `round_time`=ROUND_SEC, `countdown`=0 and tick counter = 0.
  - Otherwise: `countdown` decrements by 1.
- **PLAY**: each cycle, evaluate `h1`=`explode[p1_cor]` and `h2`=`explode[p2_cor]`.
  - h1 & h2: go to OVER with `winner`=3.
  - h1 only: go to OVER with `winner`=2.
  - h2 only: go to OVER with `winner`=1.
  - No hit, tick terminal count with `round_time`==1: `round_time` becomes 0, go to OVER with `winner`=3.
  - No hit, tick terminal count otherwise: `round_time` decrements by 1.
  - A hit takes priority over timeout in the same cycle. On a hit, `round_time` is not decremented, even on the terminal count.
- **OVER**: `winner` and `round_time` hold their values. The tick counter is held at 0. A start event goes to CLEAR.
- `play_en` = (`state`==PLAY), decoded directly from the state register.
- `field_clr` = (`state`==CLEAR).
- `sec_tick` is registered.
- Undefined state encodings (5–7) go to IDLE on the next cycle.
- Width rules:
  - The tick counter is $clog2(TICKS_PER_SEC) bits wide.
  - No counter underflows: `countdown` and `round_time` never decrement from 0.
  - Coordinates index `explode` directly, giving 0..255 with no bounds check.

## Timing
- Start edge sampled at cycle N: CLEAR at N+1, COUNTDOWN at N+2.
- PLAY at N+2+COUNTDOWN_SEC·TICKS_PER_SEC (default: N+92).
- Hit visible at PLAY cycle k: `state`=OVER, `winner` valid and `play_en`=0 at k+1. This is one-cycle latency, with no further delay.
- Timeout: OVER exactly ROUND_SEC·TICKS_PER_SEC cycles after PLAY entry.
- `sec_tick` pulses in the cycle after each terminal count, one cycle wide.
- Reset is asserted asynchronously at any point: all outputs immediately take their reset values. After release, the block stays in IDLE until a new start edge.
- A start pulse during COUNTDOWN or PLAY has no effect, and `start_q` still tracks the input.

## Test plan
- Reset, then `start` 0→1 at cycle 10:
  - `field_clr`=1 only at cycle 11.
  - `countdown`=3 at cycle 12, 2 at cycle 42, 1 at cycle 72.
  - `state`=PLAY and `round_time`=180 at cycle 102.
- In PLAY, `p1_cor`=8'h21 with `explode[33]`=1 for one cycle: next cycle `state`=OVER, `winner`=2, `play_en`=0, `round_time` held.
- In PLAY, both players on exploding tiles in the same cycle, which is also a tick terminal count with `round_time`==1: `winner`=3, and `round_time` stays 1 because the hit has priority.
- With ROUND_SEC=2 and no hits: OVER occurs 60 cycles after PLAY entry, with `winner`=3 and `round_time`=0. Then a start edge gives CLEAR, and `winner` returns to 0.
- `start` held high through reset release: block stays in IDLE. `start` toggled mid-PLAY: no state change.
- `rst` asserted mid-COUNTDOWN (`countdown`=2): same cycle, `state`=IDLE and `countdown`=0. No `field_clr` pulse occurs until the next start edge.
